// File: rtl/imem_loader_pkg.sv
// Shared state encoding and word-format constants for the instruction-memory loader.
// Optional checksum feature is controlled by the IMEM_LOADER_CHECKSUM_EN macro.
package imem_loader_pkg;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LEN  = 3'd1;
   localparam logic [2:0] DATA = 3'd2;
   localparam logic [2:0] CHK  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;
   localparam logic [2:0] ERR  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE = IDLE,
      S_LEN  = LEN,
      S_DATA = DATA,
      S_CHK  = CHK,
      S_DONE = DONE,
      S_ERR  = ERR
   } state_t;

   localparam int BYTES_PER_WORD = 4;

   // Running checksum step: the checksum is the XOR of every data byte.
   function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Word assembler for the loader: shifts in bytes MSB first and flags the byte that completes a word.
// The completed word is presented combinationally alongside the completing byte; the top registers it.
module imem_loader_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] CNT_LAST = 2'(BYTES_PER_WORD - 1);

   logic [23:0] shift_r;
   logic [1:0]  cnt_r;

   assign word       = {shift_r, din};
   assign word_valid = byte_valid & (cnt_r == CNT_LAST);

   // Byte shift register and position counter; the counter wraps naturally after the fourth byte.
   always_ff @(posedge Clk) begin
      if (Rst || clear) begin
         shift_r <= 24'd0;
         cnt_r   <= 2'd0;
      end else if (byte_valid) begin
         shift_r <= {shift_r[15:0], din};
         cnt_r   <= cnt_r + 2'd1;
      end else begin
         shift_r <= shift_r;
         cnt_r   <= cnt_r;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives length + instruction bytes (+ checksum when
// IMEM_LOADER_CHECKSUM_EN is defined) and writes 32-bit words through the IMEM write port.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [7:0]  RxData,
   input  logic        RxValid,
   output logic        RxReady,
   output logic        WEn,
   output logic [31:0] WAddr,
   output logic [31:0] WData,
   output logic        CpuHold,
   output logic        Done,
   output logic        Err
);

   localparam int DEPTH = 1 << ADDR_W;

   state_t            state_r;
   logic [ADDR_W-1:0] idx_r;
   logic [ADDR_W-1:0] last_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        chk_r;
`endif

   logic        rx_fire_s;
   logic        data_fire_s;
   logic        asm_clear_s;
   logic [31:0] asm_word_s;
   logic        asm_done_s;
   logic        len_bad_s;
   logic        last_word_s;
   logic [31:0] addr_s;

   assign rx_fire_s   = RxValid & RxReady;
   assign data_fire_s = rx_fire_s & (state_r == S_DATA);
   assign asm_clear_s = (state_r == S_LEN);
   assign len_bad_s   = (RxData == 8'd0) || ({24'd0, RxData} > 32'(DEPTH));
   assign last_word_s = (idx_r == last_r);
   assign addr_s      = 32'(idx_r) << 5'd2;

   imem_loader_word_assembler u_asm (
      .Clk        (Clk),
      .Rst        (Rst),
      .clear      (asm_clear_s),
      .byte_valid (data_fire_s),
      .din        (RxData),
      .word       (asm_word_s),
      .word_valid (asm_done_s)
   );

   // Load sequencer with registered handshake, write-port and status outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r <= S_IDLE;
         RxReady <= 1'b0;
         WEn     <= 1'b0;
         WAddr   <= 32'd0;
         WData   <= 32'd0;
         CpuHold <= 1'b1;
         Done    <= 1'b0;
         Err     <= 1'b0;
         idx_r   <= '0;
         last_r  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_r   <= 8'd0;
`endif
      end else begin
         WEn <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (Start) begin
                  state_r <= S_LEN;
                  RxReady <= 1'b1;
                  CpuHold <= 1'b1;
               end
            end
            S_LEN: begin
               if (rx_fire_s) begin
                  if (len_bad_s) begin
                     state_r <= S_ERR;
                     RxReady <= 1'b0;
                     Err     <= 1'b1;
                  end else begin
                     // Store N-1 so the final word is recognised by equality with idx.
                     last_r  <= ADDR_W'(RxData - 8'd1);
                     idx_r   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     chk_r   <= 8'd0;
`endif
                     state_r <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (rx_fire_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  chk_r <= chk_step(chk_r, RxData);
`endif
                  if (asm_done_s) begin
                     WEn   <= 1'b1;
                     WAddr <= addr_s;
                     WData <= asm_word_s;
                     idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                     if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_r <= S_CHK;
`else
                        state_r <= S_DONE;
                        RxReady <= 1'b0;
                        Done    <= 1'b1;
                        CpuHold <= 1'b0;
`endif
                     end
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
               // Words are already in IMEM; only the status reflects the checksum outcome.
               if (rx_fire_s) begin
                  RxReady <= 1'b0;
                  if (RxData == chk_r) begin
                     state_r <= S_DONE;
                     Done    <= 1'b1;
                     CpuHold <= 1'b0;
                  end else begin
                     state_r <= S_ERR;
                     Err     <= 1'b1;
                  end
               end
            end
`endif
            S_DONE: begin
               if (Start) begin
                  state_r <= S_LEN;
                  Done    <= 1'b0;
                  CpuHold <= 1'b1;
                  RxReady <= 1'b1;
               end
            end
            S_ERR: begin
               if (Start) begin
                  state_r <= S_LEN;
                  Err     <= 1'b0;
                  CpuHold <= 1'b1;
                  RxReady <= 1'b1;
               end
            end
            default: begin
               state_r <= S_IDLE;
               RxReady <= 1'b0;
               CpuHold <= 1'b1;
               Done    <= 1'b0;
               Err     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a spec-level model predicts IMEM writes and final status.
// Appends the checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Start;
   logic [7:0]  RxData;
   logic        RxValid;
   logic        RxReady;
   logic        WEn;
   logic [31:0] WAddr;
   logic [31:0] WData;
   logic        CpuHold;
   logic        Done;
   logic        Err;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [63:0] exp_q[$];
   logic [31:0] words_q[$];
   logic        prev_wen = 1'b0;

   imem_loader #(.ADDR_W(5)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .RxData(RxData), .RxValid(RxValid),
      .RxReady(RxReady), .WEn(WEn), .WAddr(WAddr), .WData(WData),
      .CpuHold(CpuHold), .Done(Done), .Err(Err)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      chk_cnt++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Write monitor: every strobe must match the oldest expected write and last one cycle.
   always @(negedge Clk) begin
      if (WEn === 1'b1) begin
         check("wen_one_cycle", {31'd0, prev_wen}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("waddr", WAddr, e[63:32]);
            check("wdata", WData, e[31:0]);
         end
      end
      prev_wen = WEn;
   end

   task automatic pulse_start();
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
   endtask

   // mode 0: always valid, 1: toggle every cycle, 2: random gaps.
   task automatic send_bytes(input logic [7:0] q[$], input int mode, input int start_at);
      int  i = 0;
      int  ph = 0;
      int  cyc = 0;
      bit  v;
      bit  fired;
      bit  pulsed = 1'b0;
      while (i < q.size()) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (ph % 2 == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         ph++;
         RxValid = v;
         RxData  = v ? q[i] : 8'($urandom);
         if (!pulsed && i == start_at) begin
            Start  = 1'b1;
            pulsed = 1'b1;
         end else begin
            Start = 1'b0;
         end
         @(negedge Clk);
         fired = v && (RxReady === 1'b1);
         @(posedge Clk); #1;
         if (fired) i++;
         cyc++;
         if (cyc > 2000) begin
            fail_now("byte_accept");
            break;
         end
      end
      RxValid = 1'b0;
      Start   = 1'b0;
   endtask

   // Model: length N in 1..32 is valid; words are sent MSB first; checksum is XOR of data bytes.
   task automatic load(input logic [7:0] len, input int mode, input int start_at,
                       input bit corrupt, input int cut);
      logic [7:0] s[$];
      logic [7:0] x = 8'd0;
      logic [7:0] b;
      bit good;
      bit exp_done;
      int waited = 0;
      good = (len != 8'd0) && (len <= 8'd32);
      s.push_back(len);
      if (good) begin
         foreach (words_q[w]) begin
            for (int k = 0; k < 4; k++) begin
               b = words_q[w][31-8*k -: 8];
               s.push_back(b);
               x = x ^ b;
            end
            if (cut < 0 || w < cut / 4) exp_q.push_back({32'(w) * 32'd4, words_q[w]});
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         s.push_back(corrupt ? (x ^ 8'h01) : x);
`endif
      end
      if (cut >= 0) begin
         while (s.size() > 1 + cut) void'(s.pop_back());
      end
      pulse_start();
      check("len_done_clr", {31'd0, Done}, 32'd0);
      check("len_err_clr", {31'd0, Err}, 32'd0);
      check("len_hold", {31'd0, CpuHold}, 32'd1);
      check("len_ready", {31'd0, RxReady}, 32'd1);
      send_bytes(s, mode, start_at);
      if (cut < 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         exp_done = good && !corrupt;
`else
         exp_done = good;
`endif
         while (!(Done === 1'b1 || Err === 1'b1) && waited < 20) begin
            @(negedge Clk);
            waited++;
         end
         if (waited >= 20) fail_now("status_wait");
         check("done", {31'd0, Done}, {31'd0, exp_done});
         check("err", {31'd0, Err}, {31'd0, !exp_done});
         check("cpuhold", {31'd0, CpuHold}, {31'd0, !exp_done});
         check("rxready_end", {31'd0, RxReady}, 32'd0);
         repeat (2) @(negedge Clk);
         check("writes_seen", exp_q.size(), 32'd0);
         @(posedge Clk); #1;
      end
   endtask

   task automatic check_reset_values();
      check("rst_rxready", {31'd0, RxReady}, 32'd0);
      check("rst_wen", {31'd0, WEn}, 32'd0);
      check("rst_waddr", WAddr, 32'd0);
      check("rst_wdata", WData, 32'd0);
      check("rst_cpuhold", {31'd0, CpuHold}, 32'd1);
      check("rst_done", {31'd0, Done}, 32'd0);
      check("rst_err", {31'd0, Err}, 32'd0);
   endtask

   task automatic rand_words(input int n);
      words_q.delete();
      for (int w = 0; w < n; w++) words_q.push_back($urandom);
   endtask

   initial begin
      Rst = 1'b1; Start = 1'b0; RxData = 8'd0; RxValid = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check_reset_values();
      Rst = 1'b0;
      @(posedge Clk); #1;

      // Directed reference stream, back-to-back then toggled valid.
      words_q.delete();
      words_q.push_back(32'h8C010004);
      words_q.push_back(32'h20220002);
      load(8'h02, 0, -1, 1'b0, -1);
      load(8'h02, 1, -1, 1'b0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      load(8'h02, 0, -1, 1'b1, -1);
`endif

      // Length boundaries.
      words_q.delete();
      load(8'h00, 0, -1, 1'b0, -1);
      load(8'h21, 0, -1, 1'b0, -1);
      load(8'($urandom_range(34, 255)), 2, -1, 1'b0, -1);
      rand_words(32);
      load(8'h20, 2, -1, 1'b0, -1);

      // Reset mid-load after 6 data bytes, then a full reload.
      rand_words(3);
      load(8'h03, 0, -1, 1'b0, 6);
      Rst = 1'b1;
      @(posedge Clk); #1;
      check_reset_values();
      Rst = 1'b0;
      @(posedge Clk); #1;
      check("exp_after_rst", exp_q.size(), 32'd0);
      rand_words(3);
      load(8'h03, 2, -1, 1'b0, -1);

      // Start during DATA ignored, then reload from DONE.
      rand_words(4);
      load(8'h04, 0, 3, 1'b0, -1);
      rand_words(2);
      load(8'h02, 0, 9, 1'b0, -1);

      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(1, 32);
         rand_words(n);
         load(8'(n), 2, -1, 1'b0, -1);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
